// File: rtl/move_event_gen_pkg.sv
// Shared constants for the frog-game move event generator: switch/direction
// indices, repeat FSM encodings and default typematic timing.
package move_event_gen_pkg;

    localparam int CLK_HZ = 25_000_000;

    localparam int DEFAULT_REPEAT_DELAY = CLK_HZ / 2;   // 500 ms
    localparam int DEFAULT_REPEAT_RATE  = CLK_HZ / 5;   // 200 ms
    localparam int DEFAULT_CNT_W        = 24;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RATE  = 2'd2
    } rpt_state_e;

    function automatic logic [1:0] lowest_index(input logic [3:0] mask);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/move_event_gen_repeat_timer.sv
// Shared typematic timer: follows the most recently pressed switch and emits
// a repeat tick after the initial delay, then at the repeat rate.
module move_event_gen_repeat_timer
    import move_event_gen_pkg::*;
#(
    parameter int c_REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int c_REPEAT_RATE  = DEFAULT_REPEAT_RATE,
    parameter bit c_REPEAT_EN    = 1'b1,
    parameter int c_CNT_W        = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] edges,
    input  logic [3:0] levels,
    output logic       tick,
    output logic [1:0] idx
);

    localparam logic [c_CNT_W-1:0] DELAY_LD = c_CNT_W'(c_REPEAT_DELAY - 1);
    localparam logic [c_CNT_W-1:0] RATE_LD  = c_CNT_W'(c_REPEAT_RATE - 1);

    rpt_state_e         state;
    logic [c_CNT_W-1:0] cnt;
    logic [1:0]         act;
    logic               any_edge;

    assign any_edge = |edges;
    // A fresh press always wins over a tick in the same cycle.
    assign tick = (state != RPT_IDLE) && !any_edge && levels[act] && (cnt == '0);
    assign idx  = act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RPT_IDLE;
            cnt   <= '0;
            act   <= 2'd0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (c_REPEAT_EN && any_edge) begin
                        act   <= lowest_index(edges);
                        cnt   <= DELAY_LD;
                        state <= RPT_DELAY;
                    end
                end
                default: begin
                    if (any_edge) begin
                        act   <= lowest_index(edges);
                        cnt   <= DELAY_LD;
                        state <= RPT_DELAY;
                    end else if (!levels[act]) begin
                        state <= RPT_IDLE;
                    end else if (cnt == '0) begin
                        cnt   <= RATE_LD;
                        state <= RPT_RATE;
                    end else begin
                        cnt <= cnt - c_CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/move_event_gen.sv
// Turns debounced switch levels into one-at-a-time move events (press edges
// plus auto-repeat) with a one-deep pending slot per switch and valid/ready out.
module move_event_gen
    import move_event_gen_pkg::*;
#(
    parameter int c_REPEAT_DELAY = DEFAULT_REPEAT_DELAY,
    parameter int c_REPEAT_RATE  = DEFAULT_REPEAT_RATE,
    parameter bit c_REPEAT_EN    = 1'b1,
    parameter int c_CNT_W        = DEFAULT_CNT_W
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Switches,
    input  logic       i_Ready,
    output logic       o_Valid,
    output logic [1:0] o_Dir,
    output logic       o_Repeat,
    output logic       o_Overrun
);

    logic [3:0] prev;
    logic [3:0] pending;
    logic [3:0] pending_rep;
    logic [3:0] edges;
    logic [3:0] rep_mask;
    logic [3:0] set_mask;
    logic [3:0] clr_mask;
    logic       tick;
    logic [1:0] tick_idx;
    logic [1:0] pick;
    logic       load;
    logic       issue;

    move_event_gen_repeat_timer #(
        .c_REPEAT_DELAY (c_REPEAT_DELAY),
        .c_REPEAT_RATE  (c_REPEAT_RATE),
        .c_REPEAT_EN    (c_REPEAT_EN),
        .c_CNT_W        (c_CNT_W)
    ) u_timer (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .edges  (edges),
        .levels (i_Switches),
        .tick   (tick),
        .idx    (tick_idx)
    );

    assign edges    = i_Switches & ~prev;
    assign rep_mask = tick ? (4'b0001 << tick_idx) : 4'b0000;
    assign set_mask = edges | rep_mask;
    assign load     = !o_Valid || i_Ready;
    assign issue    = load && (pending != 4'b0000);
    assign pick     = lowest_index(pending);
    assign clr_mask = issue ? (4'b0001 << pick) : 4'b0000;

    // prev resets to all-ones so switches held through reset need a re-press.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            prev        <= 4'b1111;
            pending     <= 4'b0000;
            pending_rep <= 4'b0000;
            o_Valid     <= 1'b0;
            o_Dir       <= 2'd0;
            o_Repeat    <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            prev      <= i_Switches;
            o_Overrun <= |(set_mask & pending & ~clr_mask);

            for (int k = 0; k < 4; k++) begin
                if (set_mask[k] && (!pending[k] || clr_mask[k])) begin
                    pending[k]     <= 1'b1;
                    pending_rep[k] <= rep_mask[k];
                end else if (clr_mask[k]) begin
                    pending[k] <= 1'b0;
                end
            end

            if (load) begin
                if (issue) begin
                    o_Valid  <= 1'b1;
                    o_Dir    <= pick;
                    o_Repeat <= pending_rep[pick];
                end else begin
                    o_Valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_move_event_gen.sv
// Directed bench for move_event_gen with a short repeat delay (8) and rate (4).
module tb_move_event_gen;
    import move_event_gen_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       ready;
    logic       valid;
    logic [1:0] dir;
    logic       rep;
    logic       ovr;

    int errors = 0;
    int checks = 0;

    move_event_gen #(
        .c_REPEAT_DELAY (8),
        .c_REPEAT_RATE  (4),
        .c_REPEAT_EN    (1'b1),
        .c_CNT_W        (8)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switches (sw),
        .i_Ready    (ready),
        .o_Valid    (valid),
        .o_Dir      (dir),
        .o_Repeat   (rep),
        .o_Overrun  (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_v;
        rst   = 1'b1;
        sw    = 4'b0001;
        ready = 1'b1;
        repeat (3) step();
        chk("reset_valid",   32'(valid), 32'd0);
        chk("reset_dir",     32'(dir),   32'd0);
        chk("reset_repeat",  32'(rep),   32'd0);
        chk("reset_overrun", 32'(ovr),   32'd0);

        // Switch 0 held through reset: no event while it stays held.
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("held_thru_reset_valid", 32'(valid), 32'd0);
        end
        sw = 4'b0000;
        step();
        sw = 4'b0001;
        step();
        chk("repress_e0_valid", 32'(valid), 32'd0);
        sw = 4'b0000;
        step();
        chk("repress_valid",  32'(valid), 32'd1);
        chk("repress_dir",    32'(dir),   32'(DIR_UP));
        chk("repress_repeat", 32'(rep),   32'd0);
        step();
        chk("repress_done", 32'(valid), 32'd0);
        repeat (2) step();

        // Hold switch 2: fresh at +1, repeats at +9, +13, +17 after sampling edge.
        sw = 4'b0100;
        for (int c = 0; c < 26; c++) begin
            step();
            if (c == 19) sw = 4'b0000;
            exp_v = (c == 1) || (c == 9) || (c == 13) || (c == 17);
            chk("hold2_valid", 32'(valid), 32'(exp_v));
            if (exp_v) begin
                chk("hold2_dir",    32'(dir), 32'(DIR_LEFT));
                chk("hold2_repeat", 32'(rep), 32'(c != 1));
            end
        end

        // Two simultaneous presses issue in ascending order.
        sw = 4'b1010;
        step();
        chk("multi_e0_valid", 32'(valid), 32'd0);
        step();
        chk("multi_a_valid",  32'(valid), 32'd1);
        chk("multi_a_dir",    32'(dir),   32'(DIR_DOWN));
        chk("multi_a_repeat", 32'(rep),   32'd0);
        step();
        chk("multi_b_valid",  32'(valid), 32'd1);
        chk("multi_b_dir",    32'(dir),   32'(DIR_RIGHT));
        chk("multi_b_repeat", 32'(rep),   32'd0);
        sw = 4'b0000;
        step();
        chk("multi_done", 32'(valid), 32'd0);
        repeat (2) step();

        // Backpressure: output holds, one pending, third press overruns.
        ready = 1'b0;
        sw = 4'b0001;
        step();
        step();
        chk("bp_valid1", 32'(valid), 32'd1);
        chk("bp_dir1",   32'(dir),   32'(DIR_UP));
        sw = 4'b0000;
        step();
        sw = 4'b0001;
        step();
        chk("bp_hold_valid", 32'(valid), 32'd1);
        chk("bp_hold_dir",   32'(dir),   32'(DIR_UP));
        chk("bp_no_ovr",     32'(ovr),   32'd0);
        sw = 4'b0000;
        step();
        sw = 4'b0001;
        step();
        chk("bp_ovr_pulse", 32'(ovr), 32'd1);
        sw = 4'b0000;
        step();
        chk("bp_ovr_end",   32'(ovr),   32'd0);
        chk("bp_still_dir", 32'(dir),   32'(DIR_UP));
        ready = 1'b1;
        step();
        chk("bp_drain2_valid",  32'(valid), 32'd1);
        chk("bp_drain2_dir",    32'(dir),   32'(DIR_UP));
        chk("bp_drain2_repeat", 32'(rep),   32'd0);
        step();
        chk("bp_drained", 32'(valid), 32'd0);
        repeat (3) step();
        chk("bp_no_extra", 32'(valid), 32'd0);

        // Retarget: switch 0 held 6 cycles, then switch 3 pressed.
        sw = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 5)  sw = 4'b1001;
            if (c == 16) sw = 4'b0000;
            exp_v = (c == 1) || (c == 7) || (c == 15);
            chk("retarget_valid", 32'(valid), 32'(exp_v));
            if (c == 1) begin
                chk("retarget_first_dir", 32'(dir), 32'(DIR_UP));
                chk("retarget_first_rep", 32'(rep), 32'd0);
            end
            if (c == 7) begin
                chk("retarget_press3_dir", 32'(dir), 32'(DIR_RIGHT));
                chk("retarget_press3_rep", 32'(rep), 32'd0);
            end
            if (c == 15) begin
                chk("retarget_rpt_dir", 32'(dir), 32'(DIR_RIGHT));
                chk("retarget_rpt_rep", 32'(rep), 32'd1);
            end
        end
        repeat (2) step();

        // Asynchronous reset mid-cycle with a held event and one pending.
        ready = 1'b0;
        sw = 4'b0001;
        step();
        sw = 4'b0000;
        step();
        chk("arst_pre_valid", 32'(valid), 32'd1);
        sw = 4'b0001;
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid_drop", 32'(valid), 32'd0);
        chk("arst_ovr",        32'(ovr),   32'd0);
        sw = 4'b0000;
        step();
        rst   = 1'b0;
        ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("arst_pending_empty", 32'(valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
